// File: rtl/fft_ctrl_pkg.sv
// State encoding and sizing helpers shared by the FFT control path
// (index sequencer and top-level control FSM).
package fft_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef logic [STATE_W-1:0] fft_state_t;

   localparam fft_state_t ST_IDLE = 2'd0;
   localparam fft_state_t ST_RUN  = 2'd1;
   localparam fft_state_t ST_DONE = 2'd2;

   // Stage counter width: enough bits for 0..n-1, never narrower than one bit.
   function automatic int stage_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/bit_reverse.sv
// Pure combinational bit-order reversal; shared with the FFT address generator.
module bit_reverse #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_rev
      assign dout[g] = din[WIDTH-1-g];
   end

endmodule

// File: rtl/fft_index_counter.sv
// Radix-2 FFT index/stage sequencer: walks 0..MAX_COUNT once per pass for
// NUM_STAGES passes, exposing natural and bit-reversed index plus pass number.
module fft_index_counter
   import fft_ctrl_pkg::*;
#(
   parameter  int WIDTH      = 4,
   parameter  int MAX_COUNT  = 2**WIDTH - 1,
   parameter  int NUM_STAGES = 4,
   localparam int STAGE_W    = stage_width(NUM_STAGES)
) (
   input  logic               clk,
   input  logic               aclr,
   input  logic               sclr,
   input  logic               start,
   input  logic               en,
   output logic [WIDTH-1:0]   out,
   output logic [WIDTH-1:0]   out_rev,
   output logic [STAGE_W-1:0] stage,
   output logic               cout,
   output logic               busy,
   output logic               done
);

   localparam logic [WIDTH-1:0]   LAST_IDX   = WIDTH'(MAX_COUNT);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

   fft_state_t         state_r, state_s;
   logic [WIDTH-1:0]   out_r,   out_s;
   logic [STAGE_W-1:0] stage_r, stage_s;
   logic               cout_r,  cout_s;
   logic               busy_r,  busy_s;
   logic               done_r,  done_s;

   // Next-state and next-output computation; pulses default low every cycle.
   always_comb begin
      state_s = state_r;
      out_s   = out_r;
      stage_s = stage_r;
      cout_s  = 1'b0;
      busy_s  = busy_r;
      done_s  = 1'b0;
      if (sclr) begin
         state_s = ST_IDLE;
         out_s   = '0;
         stage_s = '0;
         busy_s  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               out_s   = '0;
               stage_s = '0;
               if (start) begin
                  state_s = ST_RUN;
                  busy_s  = 1'b1;
               end else begin
                  busy_s  = 1'b0;
               end
            end
            ST_RUN: begin
               if (en) begin
                  // >= keeps the index bounded even if it were ever corrupted
                  if (out_r >= LAST_IDX) begin
                     out_s  = '0;
                     cout_s = 1'b1;
                     if (stage_r >= LAST_STAGE) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                     end else begin
                        stage_s = stage_r + 1'b1;
                     end
                  end else begin
                     out_s = out_r + 1'b1;
                  end
               end else begin
                  out_s = out_r;
               end
            end
            ST_DONE: begin
               state_s = ST_IDLE;
               out_s   = '0;
               stage_s = '0;
               busy_s  = 1'b0;
            end
            default: begin
               state_s = ST_IDLE;
               out_s   = '0;
               stage_s = '0;
               busy_s  = 1'b0;
            end
         endcase
      end
   end

   // State, index, stage and pulse registers with asynchronous clear.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state_r <= ST_IDLE;
         out_r   <= '0;
         stage_r <= '0;
         cout_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         out_r   <= out_s;
         stage_r <= stage_s;
         cout_r  <= cout_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   bit_reverse #(.WIDTH(WIDTH)) u_rev (
      .din  (out_r),
      .dout (out_rev)
   );

   assign out   = out_r;
   assign stage = stage_r;
   assign cout  = cout_r;
   assign busy  = busy_r;
   assign done  = done_r;

endmodule

// File: tb/tb_fft_index_counter.sv
// Self-checking bench: two sequencer configurations driven by shared stimulus,
// compared each cycle against a step-count model, plus hand-computed anchors.
module tb_fft_index_counter;

   logic       clk = 1'b0;
   logic       aclr, sclr, start, en;
   logic [3:0] out_a, rev_a, out_b, rev_b;
   logic [1:0] stage_a;
   logic [0:0] stage_b;
   logic       cout_a, busy_a, done_a, cout_b, busy_b, done_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fft_index_counter u_a (
      .clk(clk), .aclr(aclr), .sclr(sclr), .start(start), .en(en),
      .out(out_a), .out_rev(rev_a), .stage(stage_a),
      .cout(cout_a), .busy(busy_a), .done(done_a)
   );

   fft_index_counter #(.WIDTH(4), .MAX_COUNT(9), .NUM_STAGES(2)) u_b (
      .clk(clk), .aclr(aclr), .sclr(sclr), .start(start), .en(en),
      .out(out_b), .out_rev(rev_b), .stage(stage_b),
      .cout(cout_b), .busy(busy_b), .done(done_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_chk++;
      if (act !== 32'(exp)) begin
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Model: a run is just a count of enabled steps since start.
   typedef struct {
      bit running;
      int steps;
      bit cout;
      bit done;
   } m_t;

   function automatic m_t step(input m_t m, input int p, input int n,
                               input logic sc, input logic st, input logic e);
      m_t r;
      r = m;
      r.cout = 1'b0;
      r.done = 1'b0;
      if (sc || m.done) begin
         r.running = 1'b0;
         r.steps   = 0;
      end else if (!m.running) begin
         if (st) begin
            r.running = 1'b1;
            r.steps   = 0;
         end
      end else if (e) begin
         r.steps = m.steps + 1;
         r.cout  = (r.steps % p) == 0;
         if (r.steps == n * p) begin
            r.running = 1'b0;
            r.done    = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic int rev4(input int v);
      int r = 0;
      for (int i = 0; i < 4; i++) begin
         if (((v >> i) & 1) != 0) r += 1 << (3 - i);
      end
      return r;
   endfunction

   m_t ma = '{1'b0, 0, 1'b0, 1'b0};
   m_t mb = '{1'b0, 0, 1'b0, 1'b0};

   task automatic cmp(input string tag, input m_t m, input int p, input int n,
                      input logic [3:0] o, input logic [3:0] r, input logic [1:0] s,
                      input logic c, input logic b, input logic d);
      int eo, es;
      eo = m.running ? (m.steps % p) : 0;
      es = m.running ? (m.steps / p) : (m.done ? n - 1 : 0);
      chk({tag, "_out"},   32'(o), eo);
      chk({tag, "_rev"},   32'(r), rev4(eo));
      chk({tag, "_stage"}, 32'(s), es);
      chk({tag, "_cout"},  32'(c), int'(m.cout));
      chk({tag, "_busy"},  32'(b), int'(m.running));
      chk({tag, "_done"},  32'(d), int'(m.done));
   endtask

   // Model update on every DUT edge, compared just after outputs settle.
   always @(posedge clk or posedge aclr) begin
      if (aclr) begin
         ma = '{1'b0, 0, 1'b0, 1'b0};
         mb = '{1'b0, 0, 1'b0, 1'b0};
      end else begin
         ma = step(ma, 16, 4, sclr, start, en);
         mb = step(mb, 10, 2, sclr, start, en);
      end
      #1;
      cmp("a", ma, 16, 4, out_a, rev_a, stage_a, cout_a, busy_a, done_a);
      cmp("b", mb, 10, 2, out_b, rev_b, {1'b0, stage_b}, cout_b, busy_b, done_b);
   end

   initial begin
      int cc, ens;
      bit seen;
      aclr = 1'b1; sclr = 1'b0; start = 1'b0; en = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out", 32'(out_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
      aclr = 1'b0;

      // Full default run with en held high
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy_a), 1);
      chk("start_out", 32'(out_a), 0);
      en = 1'b1;
      repeat (5) @(negedge clk);
      chk("out5", 32'(out_a), 5);
      chk("rev5", 32'(rev_a), 10);
      repeat (10) @(negedge clk);
      chk("out15", 32'(out_a), 15);
      chk("out15_cout", 32'(cout_a), 0);
      @(negedge clk);
      chk("wrap_cout", 32'(cout_a), 1);
      chk("wrap_out", 32'(out_a), 0);
      chk("wrap_stage", 32'(stage_a), 1);
      @(negedge clk);
      chk("cout_pulse_end", 32'(cout_a), 0);
      cc = 1;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (cout_a) cc++;
         if (done_a) begin
            seen = 1'b1;
            chk("done_with_cout", 32'(cout_a), 1);
            chk("done_stage", 32'(stage_a), 3);
            chk("done_busy", 32'(busy_a), 0);
         end
      end
      chk("done_seen", 32'(seen), 1);
      chk("cout_pulses", 32'(cc), 4);

      // Back-to-back: start held across DONE, takes effect from IDLE
      start = 1'b1;
      @(negedge clk);
      chk("idle_after_done_busy", 32'(busy_a), 0);
      chk("idle_after_done_stage", 32'(stage_a), 0);
      chk("idle_after_done_done", 32'(done_a), 0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 32'(busy_a), 1);
      chk("b2b_out", 32'(out_a), 0);
      chk("b2b_stage", 32'(stage_a), 0);
      repeat (3) @(negedge clk);
      chk("pre_sclr_out", 32'(out_a), 3);
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0;
      chk("sclr_out", 32'(out_a), 0);
      chk("sclr_busy", 32'(busy_a), 0);

      // start during RUN is ignored; then async clear mid-run at out=7
      start = 1'b1; en = 1'b0;
      @(negedge clk);
      start = 1'b0; en = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_run_out", 32'(out_a), 4);
      chk("start_in_run_busy", 32'(busy_a), 1);
      repeat (3) @(negedge clk);
      chk("pre_aclr_out", 32'(out_a), 7);
      en = 1'b0;
      #2 aclr = 1'b1;
      #1;
      chk("aclr_out", 32'(out_a), 0);
      chk("aclr_busy", 32'(busy_a), 0);
      chk("aclr_stage", 32'(stage_a), 0);
      chk("aclr_cout", 32'(cout_a), 0);
      chk("aclr_done", 32'(done_a), 0);
      @(negedge clk);
      aclr = 1'b0;

      // Short configuration with en toggling: done after 20 enabled edges
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ens = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         en = i[0];
         if (en) ens++;
         @(negedge clk);
         if (done_b) seen = 1'b1;
      end
      chk("b_done_seen", 32'(seen), 1);
      chk("b_enabled_edges", 32'(ens), 20);
      en = 1'b0;

      // Randomised traffic, including occasional sync and async clears
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 7) == 0);
         en    = ($urandom_range(0, 3) != 0);
         sclr  = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 aclr = 1'b1;
            @(negedge clk);
            aclr = 1'b0;
         end
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
